flag_ctx_ctrl: RTL and testbench
================================

// Module: flag_ctx_ctrl
// PURPOSE
//  Sequencer for the 5-bit flag register {N,Z,C,V,MODE}. Owns update_mode: passes decoder flag-update requests
//  through in normal operation, sequences SWI entry (save flags, toggle MODE), RTI (restore flags), HALT and fault.
//  Keeps a LIFO of saved flag contexts. Sits between instruction decoder and flag register; stalls the pipeline.
// PARAMETERS
//  DEPTH   4   saved flag contexts in LIFO (>=1)
//  FW      5   flag word width {N,Z,C,V,MODE}
// PORTS
//  clock          in   1    posedge clock; flag register samples update_mode on following negedge
//  reset          in   1    synchronous, active-high
//  upd_req        in   3    decoder flag-update class (0 none,1 BS NZC,2 ALU NZCV,3 MOV NZ,4 V only)
//  swi_req        in   1    software-interrupt pulse, sampled only in IDLE
//  rti_req        in   1    return-from-interrupt pulse, sampled only in IDLE
//  halt_req       in   1    halt pulse, sampled only in IDLE
//  flags_in       in   FW   current flag register value
//  update_mode    out  3    to flag register: 0..4 passthrough, 5 toggle MODE, 6 set all, 7 load restore_flags
//  restore_flags  out  FW   top-of-LIFO value, valid when update_mode==7
//  stall          out  1    freeze fetch/decode this cycle
//  vector_en      out  1    1-cycle pulse: load PC with SWI vector
//  halted         out  1    in HALTED state
//  fault          out  1    sticky: LIFO overflow or underflow occurred
//  depth          out  $clog2(DEPTH+1)  current LIFO occupancy
// BEHAVIOUR
//  Reset: state=IDLE, sp=0, fault=0; update_mode=0, stall=0, vector_en=0, halted=0, restore_flags=0. LIFO data undefined.
//  Reset beats every other input, including mid-sequence; an interrupted SWI/RTI is abandoned with no flag change.
//  Outputs are combinational from state+inputs; state, sp, LIFO, fault are registered on posedge.
//  Priority in IDLE: halt_req > swi_req > rti_req > upd_req. Losers are dropped, not queued.
//  IDLE: no request -> update_mode=upd_req if 0..4, else 0 (decoder codes 5..7 are illegal, ignored); stall=0.
//  IDLE+halt_req -> update_mode=6, stall=1; next HALTED.
//  IDLE+swi_req: sp<DEPTH -> push flags_in, sp+1, update_mode=0, stall=1; next SWI_TOGGLE.
//                sp==DEPTH -> no push, fault<=1, stall=1; next FAULT.
//  SWI_TOGGLE: update_mode=5, vector_en=1, stall=1; next IDLE. SWI latency: 2 cycles of stall.
//  IDLE+rti_req: sp>0 -> update_mode=7, restore_flags=LIFO[sp-1], pop (sp-1), stall=1; next RTI_SETTLE.
//                sp==0 -> update_mode=0, fault<=1, stall=1; next FAULT.
//  RTI_SETTLE: update_mode=0, stall=1; next IDLE (restored flags visible to decoder here). RTI latency: 2 cycles.
//  FAULT: update_mode=6, stall=1; next HALTED.
//  HALTED: update_mode=0, stall=1, halted=1; all requests ignored; exit only via reset.
//  Requests presented outside IDLE are ignored (pipeline is frozen while stall=1).
//  restore_flags = LIFO[sp-1] whenever sp>0, else 0. sp never wraps: full/empty are faults, not wrap-around.
//  Push of a full LIFO or pop of an empty one never modifies LIFO contents or sp.
// STRUCTURE
//  Shared package flag_ctx_pkg: state enum {IDLE,SWI_TOGGLE,RTI_SETTLE,FAULT,HALTED}; update_mode codes
//  UPD_NONE=0,UPD_BS=1,UPD_ALU=2,UPD_MOV=3,UPD_OVF=4,UPD_SWI=5,UPD_HALT=6,UPD_RESTORE=7 (shared with decoder
//  and flag register). One sub-module: flag_lifo (DEPTH x FW, push/pop/top/count/full/empty, sync reset of count).
// TESTING
//  1 Passthrough: IDLE, upd_req=2,3,1,4,6 on successive cycles -> update_mode=2,3,1,4,0; stall=0 throughout.
//  2 SWI: flags_in=5'b10100, swi_req -> cyc0 mode 0 stall 1, cyc1 mode 5 vector_en 1, cyc2 IDLE, depth=1.
//  3 Nested SWI/RTI: push 5'h14,5'h09 then two rti_req -> restore_flags 5'h09 then 5'h14 with mode 7; depth 2->1->0.
//  4 Boundaries: DEPTH=4, five swi_req -> 5th sets fault, mode 6 then halted=1; fresh reset, rti_req at depth 0
//    -> fault=1, FAULT then HALTED; requests in HALTED ignored.
//  5 Priority: halt_req+swi_req+upd_req=2 same cycle -> mode 6, no push (depth unchanged), HALTED next.
//  6 Reset mid-op: reset asserted in SWI_TOGGLE -> next cycle IDLE, depth=0, all outputs 0, no mode 5 issued.

Source files
------------

// File: rtl/flag_ctx_pkg.sv
// Shared definitions for the flag-context sequencer, the instruction decoder
// and the flag register: controller states and flag-register update codes.
package flag_ctx_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int FW_DEF    = 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SWI_TOGGLE = 3'd1,
        RTI_SETTLE = 3'd2,
        FAULT      = 3'd3,
        HALTED     = 3'd4
    } ctx_state_e;

    typedef enum logic [2:0] {
        UPD_NONE    = 3'd0,
        UPD_BS      = 3'd1,
        UPD_ALU     = 3'd2,
        UPD_MOV     = 3'd3,
        UPD_OVF     = 3'd4,
        UPD_SWI     = 3'd5,
        UPD_HALT    = 3'd6,
        UPD_RESTORE = 3'd7
    } upd_mode_e;

endpackage

// File: rtl/flag_lifo.sv
// LIFO of saved flag words. Push on full and pop on empty are silently
// refused so the contents and occupancy are never corrupted; the caller
// decides whether that is a fault. Only the occupancy is reset.
module flag_lifo #(
    parameter int DEPTH = 4,
    parameter int FW    = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [FW-1:0]                din,
    output logic [FW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wr_idx  = AW'(count_q);
    assign top_idx = AW'(count_q - CW'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    // Next contents and occupancy; guarded push/pop never touch a full/empty stack.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            count_d       = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage has no reset; entries above the occupancy are never read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flag_ctx_ctrl.sv
// Flag-context sequencer: passes decoder flag-update requests to the flag
// register and sequences SWI entry, RTI, HALT and the fault path. Outputs are
// combinational from state and inputs and are forced quiet while reset is high.
module flag_ctx_ctrl
    import flag_ctx_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int FW    = FW_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   upd_req,
    input  logic                         swi_req,
    input  logic                         rti_req,
    input  logic                         halt_req,
    input  logic [FW-1:0]                flags_in,
    output logic [2:0]                   update_mode,
    output logic [FW-1:0]                restore_flags,
    output logic                         stall,
    output logic                         vector_en,
    output logic                         halted,
    output logic                         fault,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    ctx_state_e    state_q, state_d;
    logic          fault_q, fault_d;
    logic          push, pop;
    logic          lifo_full, lifo_empty;
    logic [FW-1:0] lifo_top;

    flag_lifo #(
        .DEPTH (DEPTH),
        .FW    (FW)
    ) u_lifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (flags_in),
        .top   (lifo_top),
        .count (depth),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    assign fault         = fault_q;
    assign restore_flags = (reset || lifo_empty) ? '0 : lifo_top;

    // Next-state and output decode; reset silences everything so an
    // interrupted SWI/RTI never reaches the flag register.
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        update_mode = UPD_NONE;
        stall       = 1'b0;
        vector_en   = 1'b0;
        halted      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt_req) begin
                    update_mode = UPD_HALT;
                    stall       = 1'b1;
                    state_d     = HALTED;
                end else if (swi_req) begin
                    stall = 1'b1;
                    if (!lifo_full) begin
                        push    = 1'b1;
                        state_d = SWI_TOGGLE;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end else if (rti_req) begin
                    stall = 1'b1;
                    if (!lifo_empty) begin
                        update_mode = UPD_RESTORE;
                        pop         = 1'b1;
                        state_d     = RTI_SETTLE;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end else if (upd_req <= 3'(UPD_OVF)) begin
                    update_mode = upd_req;
                end
            end
            SWI_TOGGLE: begin
                update_mode = UPD_SWI;
                vector_en   = 1'b1;
                stall       = 1'b1;
                state_d     = IDLE;
            end
            RTI_SETTLE: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            FAULT: begin
                update_mode = UPD_HALT;
                stall       = 1'b1;
                state_d     = HALTED;
            end
            HALTED: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            update_mode = UPD_NONE;
            stall       = 1'b0;
            vector_en   = 1'b0;
            halted      = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
        end
    end

    // State and sticky fault registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_flag_ctx_ctrl.sv
// Directed self-checking bench for flag_ctx_ctrl (DEPTH=4, FW=5).
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_flag_ctx_ctrl;

    logic       clock;
    logic       reset;
    logic [2:0] upd_req;
    logic       swi_req;
    logic       rti_req;
    logic       halt_req;
    logic [4:0] flags_in;
    logic [2:0] update_mode;
    logic [4:0] restore_flags;
    logic       stall;
    logic       vector_en;
    logic       halted;
    logic       fault;
    logic [2:0] depth;

    int checks = 0;
    int passes = 0;

    flag_ctx_ctrl #(
        .DEPTH (4),
        .FW    (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .upd_req       (upd_req),
        .swi_req       (swi_req),
        .rti_req       (rti_req),
        .halt_req      (halt_req),
        .flags_in      (flags_in),
        .update_mode   (update_mode),
        .restore_flags (restore_flags),
        .stall         (stall),
        .vector_en     (vector_en),
        .halted        (halted),
        .fault         (fault),
        .depth         (depth)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks every control output against expected values.
    task automatic checkOutput(input string tag, input int e_mode, input int e_stall,
                               input int e_vec, input int e_halted, input int e_fault,
                               input int e_depth);
        checkVal({tag, ".mode"},   32'(update_mode), 32'(e_mode));
        checkVal({tag, ".stall"},  32'(stall),       32'(e_stall));
        checkVal({tag, ".vec"},    32'(vector_en),   32'(e_vec));
        checkVal({tag, ".halted"}, 32'(halted),      32'(e_halted));
        checkVal({tag, ".fault"},  32'(fault),       32'(e_fault));
        checkVal({tag, ".depth"},  32'(depth),       32'(e_depth));
    endtask

    // Drives one cycle's worth of inputs (reset released) and lets them settle.
    task automatic applyStimulus(input logic [2:0] upd, input logic swi, input logic rti,
                                 input logic halt, input logic [4:0] flags);
        @(negedge clock);
        reset    = 1'b0;
        upd_req  = upd;
        swi_req  = swi;
        rti_req  = rti;
        halt_req = halt;
        flags_in = flags;
        #1;
    endtask

    // Holds reset for two rising edges with all requests idle.
    task automatic doReset();
        @(negedge clock);
        reset    = 1'b1;
        upd_req  = 3'd0;
        swi_req  = 1'b0;
        rti_req  = 1'b0;
        halt_req = 1'b0;
        flags_in = 5'd0;
        repeat (2) @(posedge clock);
    endtask

    // Directed sequence.
    initial begin
        logic [2:0] pass_in  [5];
        logic [2:0] pass_exp [5];
        pass_in  = '{3'd2, 3'd3, 3'd1, 3'd4, 3'd6};
        pass_exp = '{3'd2, 3'd3, 3'd1, 3'd4, 3'd0};

        doReset();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("reset", 0, 0, 0, 0, 0, 0);
        checkVal("reset.restore", 32'(restore_flags), 32'h0);

        // Passthrough and illegal decoder codes.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pass_in[i], 1'b0, 1'b0, 1'b0, 5'd0);
            checkVal($sformatf("pass%0d.mode", i), 32'(update_mode), 32'(pass_exp[i]));
            checkVal($sformatf("pass%0d.stall", i), 32'(stall), 32'h0);
        end
        applyStimulus(3'd7, 1'b0, 1'b0, 1'b0, 5'd0);
        checkVal("illegal7.mode", 32'(update_mode), 32'h0);

        // SWI entry with flags 10100.
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 5'b10100);
        checkOutput("swi.c0", 0, 1, 0, 0, 0, 0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("swi.c1", 5, 1, 1, 0, 0, 1);
        checkVal("swi.c1.restore", 32'(restore_flags), 32'h14);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("swi.c2", 0, 0, 0, 0, 0, 1);

        // Nested: second push, then two returns.
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 5'h09);
        checkOutput("nest.swi.c0", 0, 1, 0, 0, 0, 1);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("nest.swi.c1", 5, 1, 1, 0, 0, 2);
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("rti1.c0", 7, 1, 0, 0, 0, 2);
        checkVal("rti1.restore", 32'(restore_flags), 32'h09);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rti1.c1", 0, 1, 0, 0, 0, 1);
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("rti2.c0", 7, 1, 0, 0, 0, 1);
        checkVal("rti2.restore", 32'(restore_flags), 32'h14);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rti2.c1", 0, 1, 0, 0, 0, 0);
        checkVal("rti2.c1.restore", 32'(restore_flags), 32'h0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rti2.idle", 0, 0, 0, 0, 0, 0);

        // Overflow: four pushes fill the LIFO, the fifth faults.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 5'(i + 1));
            checkVal($sformatf("fill%0d.stall", i), 32'(stall), 32'h1);
            applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
            checkVal($sformatf("fill%0d.mode", i), 32'(update_mode), 32'h5);
        end
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 5'h1F);
        checkOutput("ovf.c0", 0, 1, 0, 0, 0, 4);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("ovf.fault", 6, 1, 0, 0, 1, 4);
        applyStimulus(3'd2, 1'b1, 1'b1, 1'b1, 5'h1F);
        checkOutput("ovf.halted", 0, 1, 0, 1, 1, 4);
        checkVal("ovf.restore", 32'(restore_flags), 32'h04);
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("ovf.halted2", 0, 1, 0, 1, 1, 4);

        // Underflow: return with an empty LIFO.
        doReset();
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 5'd0);
        checkOutput("unf.c0", 0, 1, 0, 0, 0, 0);
        checkVal("unf.restore", 32'(restore_flags), 32'h0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("unf.fault", 6, 1, 0, 0, 1, 0);
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 5'h0A);
        checkOutput("unf.halted", 0, 1, 0, 1, 1, 0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("unf.halted2", 0, 1, 0, 1, 1, 0);

        // Priority: halt beats swi and upd.
        doReset();
        applyStimulus(3'd2, 1'b1, 1'b0, 1'b1, 5'h11);
        checkOutput("prio.c0", 6, 1, 0, 0, 0, 0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("prio.c1", 0, 1, 0, 1, 0, 0);

        // Reset while in SWI_TOGGLE: no mode 5 is issued.
        doReset();
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 5'h1F);
        checkOutput("rmid.c0", 0, 1, 0, 0, 0, 0);
        @(negedge clock);
        reset   = 1'b1;
        swi_req = 1'b0;
        #1;
        checkVal("rmid.rst.mode", 32'(update_mode), 32'h0);
        checkVal("rmid.rst.vec",  32'(vector_en),   32'h0);
        checkVal("rmid.rst.stall", 32'(stall),      32'h0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("rmid.idle", 0, 0, 0, 0, 0, 0);
        checkVal("rmid.restore", 32'(restore_flags), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
